// File: rtl/sram_stream_tester_if.sv
// Stream pair between the tester and the reversing SRAM buffer.
// The tester drives tx_* into the buffer and takes rx_* back from it.
interface sram_stream_tester_if #(
  parameter int WIDTH = 512
) ();
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport master (output tx_data, output tx_valid, input rx_data, input rx_valid);
  modport slave  (input tx_data, input tx_valid, output rx_data, output rx_valid);
endinterface

// File: rtl/sram_stream_tester.sv
// Transmits DEPTH seeded pattern beats, then checks the buffer returns them
// last-beat-first, reporting error count, first failing beat and pass/fail.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SEND  | driving pattern beats 0..DEPTH-1 (optionally gapped)
// WAIT  | all beats sent, waiting for the first returned beat
// CHECK | comparing returned beats against the reversed pattern
// DONE  | results held until the next start
module sram_stream_tester #(
  parameter int DEPTH   = 64,
  parameter int WIDTH   = 512,
  parameter int TIMEOUT = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              seed,
  input  logic                     gap_en,
  sram_stream_tester_if.master     strm,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [6:0]               err_cnt,
  output logic [$clog2(DEPTH)-1:0] first_err_idx
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE} state_t;

  state_t           state;
  logic [31:0]      seed_q;
  logic [IDX_W-1:0] tx_idx;
  logic [IDX_W-1:0] rx_idx;
  logic [WD_W-1:0]  wdog;

  // Word j of beat idx is seed + {idx, j}; the index field is zero-extended.
  function automatic logic [WIDTH-1:0] beat(input logic [31:0] s, input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int j = 0; j < WIDTH / 32; j++)
      b[32*j +: 32] = s + {{(28 - IDX_W){1'b0}}, idx, j[3:0]};
    return b;
  endfunction

  logic [IDX_W-1:0] tx_next;
  logic [WIDTH-1:0] exp_beat;
  logic             mismatch;
  logic [6:0]       err_next;

  assign tx_next  = tx_idx + 1'b1;
  assign exp_beat = beat(seed_q, LAST - rx_idx);
  assign mismatch = (strm.rx_data != exp_beat);
  assign err_next = (mismatch && err_cnt != 7'd127) ? err_cnt + 7'd1 : err_cnt;

  assign busy = (state == SEND) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      seed_q        <= '0;
      tx_idx        <= '0;
      rx_idx        <= '0;
      wdog          <= '0;
      strm.tx_data  <= '0;
      strm.tx_valid <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= SEND;
            seed_q        <= seed;
            tx_idx        <= '0;
            rx_idx        <= '0;
            wdog          <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            timeout       <= 1'b0;
            pass          <= 1'b0;
            strm.tx_valid <= 1'b1;
            strm.tx_data  <= beat(seed, '0);
          end
        end
        SEND: begin
          if (strm.tx_valid) begin
            if (tx_idx == LAST) begin
              state         <= WAIT;
              strm.tx_valid <= 1'b0;
              strm.tx_data  <= '0;
              wdog          <= '0;
            end else if (gap_en) begin
              strm.tx_valid <= 1'b0;
            end else begin
              tx_idx       <= tx_next;
              strm.tx_data <= beat(seed_q, tx_next);
            end
          end else begin
            tx_idx        <= tx_next;
            strm.tx_valid <= 1'b1;
            strm.tx_data  <= beat(seed_q, tx_next);
          end
        end
        WAIT, CHECK: begin
          if (strm.rx_valid) begin
            wdog    <= '0;
            rx_idx  <= rx_idx + 1'b1;
            err_cnt <= err_next;
            // err_cnt never returns to zero, so zero means no earlier mismatch
            if (mismatch && err_cnt == 7'd0)
              first_err_idx <= rx_idx;
            if (rx_idx == LAST) begin
              state   <= DONE;
              pass    <= (err_next == 7'd0);
              timeout <= 1'b0;
            end else begin
              state <= CHECK;
            end
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            state   <= DONE;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
